// File: rtl/linear_weight_server_if.sv
// Host load stream and segment read port of the Linear-layer weight/bias server.
interface linear_weight_server_if #(
    parameter int IN  = 16,
    parameter int OUT = 16,
    parameter int AW  = 8
);
    logic                  ld_start;
    logic                  ld_valid;
    logic [7:0]            ld_data;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  loaded;
    logic                  ld_err;
    logic [AW-1:0]         seg_addr;
    logic [0:IN*OUT*8+7]   w;
    logic [0:OUT*16+7]     b;

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, seg_addr,
        output ld_ready, loaded, ld_err, w, b
    );
    modport master (
        output ld_start, ld_valid, ld_data, ld_last, seg_addr,
        input  ld_ready, loaded, ld_err, w, b
    );
endinterface

// File: rtl/linear_weight_server.sv
// Weight/bias store for a Linear layer: loaded from a host byte stream, then
// serves whole-segment weight words and the bias vector with 1-cycle read latency.
module linear_weight_server #(
    parameter int IN   = 16,
    parameter int OUT  = 16,
    parameter int SEGS = 1,
    parameter int AW   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    linear_weight_server_if.slave  bus
);
    localparam int WB  = IN * OUT;
    localparam int BB  = 2 * OUT;
    localparam int CW  = $clog2((WB > BB ? WB : BB) + 1);
    localparam int SCW = $clog2(SEGS + 1);

    typedef enum logic [1:0] {IDLE, LD_BIAS, LD_W, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SCW-1:0]     seg_q, seg_d;
    logic               loaded_q, loaded_d;
    logic               err_q, err_d;
    logic [0:BB*8-1]    bias_q, bias_d;
    logic [0:WB*8-1]    stage_q, stage_d;
    logic [0:WB*8+7]    w_q, w_d;
    logic [0:OUT*16+7]  b_q, b_d;
    logic [0:WB*8-1]    mem_q [SEGS];
    logic [0:WB*8-1]    rd_word;
    logic               mem_we;
    logic               acc;

    assign bus.ld_ready = (state_q == LD_BIAS) || (state_q == LD_W);
    assign acc          = bus.ld_valid && bus.ld_ready;
    assign bus.loaded   = loaded_q;
    assign bus.ld_err   = err_q;
    assign bus.w        = w_q;
    assign bus.b        = b_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seg_d    = seg_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        bias_d   = bias_q;
        stage_d  = stage_q;
        mem_we   = 1'b0;
        // A start pulse overrides any byte presented in the same cycle.
        if (bus.ld_start) begin
            state_d  = LD_BIAS;
            cnt_d    = '0;
            seg_d    = '0;
            loaded_d = 1'b0;
            err_d    = 1'b0;
        end else if (acc) begin
            case (state_q)
                LD_BIAS: begin
                    bias_d[int'(cnt_q)*8 +: 8] = bus.ld_data;
                    if (bus.ld_last) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (int'(cnt_q) == BB-1) begin
                        state_d = LD_W;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LD_W: begin
                    stage_d[int'(cnt_q)*8 +: 8] = bus.ld_data;
                    if (int'(cnt_q) == WB-1) begin
                        mem_we = 1'b1;
                        cnt_d  = '0;
                        seg_d  = seg_q + 1'b1;
                        if (int'(seg_q) == SEGS-1) begin
                            state_d  = bus.ld_last ? DONE : IDLE;
                            loaded_d = bus.ld_last;
                            err_d    = !bus.ld_last;
                        end else if (bus.ld_last) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (bus.ld_last) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Out-of-range addresses match no segment and read back as zero.
    always_comb begin
        rd_word = '0;
        for (int s = 0; s < SEGS; s++)
            if (bus.seg_addr == AW'(s)) rd_word = mem_q[s];
        w_d = '0;
        b_d = '0;
        if (loaded_q) begin
            w_d[0:WB*8-1] = rd_word;
            b_d[0:BB*8-1] = bias_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            seg_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            bias_q   <= '0;
            stage_q  <= '0;
            w_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seg_q    <= seg_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            bias_q   <= bias_d;
            stage_q  <= stage_d;
            w_q      <= w_d;
            b_q      <= b_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < SEGS; s++)
            if (mem_we && seg_q == SCW'(s)) mem_q[s] <= stage_d;
    end
endmodule
